// File: rtl/retospect_cfg_pkg.sv
// Shared types and constants for the neurochip configuration-chain loader.
package retospect_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERIFY,
    ST_FINISH
  } state_t;

  localparam int CLOCKBOX_BITS = 48;
  localparam int CNB_BITS      = 19;
  localparam int X_MAX         = 5;
  localparam int Y_MAX         = 5;
  localparam int CHAIN_LEN     = CLOCKBOX_BITS + CNB_BITS * X_MAX * Y_MAX;
  localparam int CNT_W         = $clog2(CHAIN_LEN + 1);

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // One MSB-first step of CRC-16-CCITT for a single serial bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    return {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/retospect_cfg_loader_if.sv
// Valid/ready byte stream feeding the configuration loader.
interface retospect_cfg_loader_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/retospect_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator used by the readback pass.
// Only present when RETOSPECT_CFG_READBACK_EN is defined.
`ifdef RETOSPECT_CFG_READBACK_EN
module retospect_crc16_serial
  import retospect_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   crc <= CRC_INIT;
    else if (clr) crc <= CRC_INIT;
    else if (en)  crc <= crc16_step(crc, bit_in);
  end
endmodule
`endif

// File: rtl/retospect_cfg_loader.sv
// Byte-parallel to bit-serial loader for the neurochip configuration chain.
// Define RETOSPECT_CFG_READBACK_EN to add the CRC-checked readback pass.
module retospect_cfg_loader
  import retospect_cfg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  retospect_cfg_loader_if.slave stream,
  output logic                  config_en,
  output logic                  bs_out,
  input  logic                  bs_in,
  output logic                  nn_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  verify_err
);
  localparam logic [CNT_W-1:0] CHAIN_BITS = CNT_W'(CHAIN_LEN);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bits_left;
  logic [6:0]       sh_data;
  logic [2:0]       sh_left;
  logic [2:0]       first_left;
  logic             bs_q;
  logic             accept;

  // bit_cnt counts bits already placed on bs_out, so a byte can be taken
  // in the same cycle the previous byte's last bit is on the wire.
  assign stream.din_ready = (state == ST_LOAD) && (sh_left == 3'd0) && (bit_cnt != CHAIN_BITS);
  assign accept           = stream.din_valid && stream.din_ready;
  assign busy             = (state != ST_IDLE);
  assign bits_left        = CHAIN_BITS - bit_cnt;
  assign first_left       = (bits_left >= CNT_W'(8)) ? 3'd7 : 3'(bits_left - 1'b1);

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every branch sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      sh_data   <= '0;
      sh_left   <= 3'd0;
      bs_q      <= 1'b0;
      config_en <= 1'b0;
      done      <= 1'b0;
      nn_reset  <= 1'b0;
    end else if (abort) begin
      state     <= ST_IDLE;
      sh_left   <= 3'd0;
      bs_q      <= 1'b0;
      config_en <= 1'b0;
      done      <= 1'b0;
      nn_reset  <= 1'b0;
    end else begin
      done     <= 1'b0;
      nn_reset <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_LOAD;
            bit_cnt <= '0;
            sh_left <= 3'd0;
          end
        end
        ST_LOAD: begin
          if (bit_cnt == CHAIN_BITS) begin
`ifdef RETOSPECT_CFG_READBACK_EN
            state     <= ST_VERIFY;
            bit_cnt   <= '0;
            config_en <= 1'b1;
`else
            state     <= ST_FINISH;
            config_en <= 1'b0;
            done      <= 1'b1;
            nn_reset  <= 1'b1;
`endif
          end else if (sh_left != 3'd0) begin
            config_en <= 1'b1;
            bs_q      <= sh_data[0];
            sh_data   <= {1'b0, sh_data[6:1]};
            sh_left   <= sh_left - 1'b1;
            bit_cnt   <= bit_cnt + 1'b1;
          end else if (accept) begin
            config_en <= 1'b1;
            bs_q      <= stream.din[0];
            sh_data   <= stream.din[7:1];
            sh_left   <= first_left;
            bit_cnt   <= bit_cnt + 1'b1;
          end else begin
            config_en <= 1'b0;
          end
        end
`ifdef RETOSPECT_CFG_READBACK_EN
        ST_VERIFY: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CHAIN_BITS - 1'b1) begin
            state     <= ST_FINISH;
            config_en <= 1'b0;
            done      <= 1'b1;
            nn_reset  <= 1'b1;
          end
        end
`endif
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

`ifdef RETOSPECT_CFG_READBACK_EN
  logic [15:0] crc_load;
  logic [15:0] crc_chk;
  logic        crc_clr;

  assign crc_clr = (state == ST_IDLE) && start && !abort;

  retospect_crc16_serial u_crc_load (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (crc_clr),
    .en     ((state == ST_LOAD) && config_en),
    .bit_in (bs_q),
    .crc    (crc_load)
  );

  retospect_crc16_serial u_crc_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (crc_clr),
    .en     (state == ST_VERIFY),
    .bit_in (bs_in),
    .crc    (crc_chk)
  );

  // Unregistered tail-to-head path keeps the loop exactly CHAIN_LEN long.
  assign bs_out = (state == ST_VERIFY) ? bs_in : bs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      verify_err <= 1'b0;
    end else if (!abort) begin
      if ((state == ST_IDLE) && start)                      verify_err <= 1'b0;
      else if ((state == ST_FINISH) && (crc_load != crc_chk)) verify_err <= 1'b1;
    end
  end
`else
  logic unused_bs_in;
  assign unused_bs_in = bs_in;
  assign bs_out       = bs_q;
  assign verify_err   = 1'b0;
`endif

endmodule

// File: tb/tb_retospect_cfg_loader.sv
// Self-checking bench: feeds byte streams into retospect_cfg_loader and checks
// load timing and the contents of a behavioural model of the configuration chain.
module tb_retospect_cfg_loader;
  import retospect_cfg_pkg::*;

  localparam int NUM_BYTES = (CHAIN_LEN + 7) / 8;
  localparam int STUCK_POS = 300;
`ifdef RETOSPECT_CFG_READBACK_EN
  localparam int EXP_EN = 2 * CHAIN_LEN;
`else
  localparam int EXP_EN = CHAIN_LEN;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic start;
  logic abort;
  logic config_en, bs_out, bs_in, nn_reset, busy, done, verify_err;

  int vectors     = 0;
  int miscompares = 0;

  retospect_cfg_loader_if stream ();

  retospect_cfg_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .stream     (stream),
    .config_en  (config_en),
    .bs_out     (bs_out),
    .bs_in      (bs_in),
    .nn_reset   (nn_reset),
    .busy       (busy),
    .done       (done),
    .verify_err (verify_err)
  );

  always #5 clk = ~clk;

  // Chain model: head at bit 0, tail at CHAIN_LEN-1 feeds back to the loader.
  logic [CHAIN_LEN-1:0] chain = '0;
  bit stuck_en = 1'b0;
  assign bs_in = chain[CHAIN_LEN-1];
  always @(posedge clk) begin
    if (config_en) chain <= {chain[CHAIN_LEN-2:0], bs_out};
    if (stuck_en)  chain[STUCK_POS] <= 1'b1;
  end

  // Cumulative activity counters sampled on the falling edge.
  int   en_cnt = 0, en_rise = 0, done_cnt = 0, nnr_cnt = 0, done_ok = 0;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (config_en)               en_cnt   <= en_cnt + 1;
    if (config_en && !prev_en)   en_rise  <= en_rise + 1;
    if (done)                    done_cnt <= done_cnt + 1;
    if (nn_reset)                nnr_cnt  <= nnr_cnt + 1;
    if (done && nn_reset && prev_en) done_ok <= done_ok + 1;
    prev_en <= config_en;
  end

  function automatic logic [7:0] byte_of(input int i, input int seed);
    return 8'((i * 73 + seed * 29 + 5) ^ (i << 3));
  endfunction

  // Stream bit k ends up at chain position CHAIN_LEN-1-k after a full load.
  function automatic logic [CHAIN_LEN-1:0] expected_chain(input int seed);
    logic [CHAIN_LEN-1:0] e;
    logic [7:0] b;
    e = '0;
    for (int k = 0; k < CHAIN_LEN; k++) begin
      b = byte_of(k / 8, seed);
      e[CHAIN_LEN-1-k] = b[k % 8];
    end
    return e;
  endfunction

  task automatic start_load();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Offers bytes at falling edges; a byte counts as taken when valid and ready
  // are both high there, since neither can change before the next rising edge.
  task automatic drive_bytes(input int seed, input bit gaps, input int stop_bits, output int acc);
    int guard, base;
    acc = 0; guard = 0; base = en_cnt;
    while (acc < NUM_BYTES && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (stop_bits > 0 && (en_cnt - base) >= stop_bits) break;
      stream.din       = byte_of(acc, seed);
      stream.din_valid = gaps ? (guard % 5 != 4) : 1'b1;
      if (stream.din_valid && stream.din_ready) acc++;
    end
    if (stop_bits == 0) begin
      @(negedge clk);
      stream.din_valid = 1'b0;
    end
  endtask

  task automatic wait_done(output int late, output bit seen);
    late = 0; seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      if (stream.din_ready) late++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (config_en !== 1'b0) begin miscompares++; $display("FAIL reset_config_en got %b want 0", config_en); end
    vectors++; if (bs_out !== 1'b0) begin miscompares++; $display("FAIL reset_bs_out got %b want 0", bs_out); end
    vectors++; if (stream.din_ready !== 1'b0) begin miscompares++; $display("FAIL reset_din_ready got %b want 0", stream.din_ready); end
    vectors++; if (nn_reset !== 1'b0) begin miscompares++; $display("FAIL reset_nn_reset got %b want 0", nn_reset); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (verify_err !== 1'b0) begin miscompares++; $display("FAIL reset_verify_err got %b want 0", verify_err); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if ({busy, stream.din_ready} !== 2'b00) begin miscompares++; $display("FAIL idle_after_reset busy/ready got %b want 00", {busy, stream.din_ready}); end
  endtask

  task automatic test_full_load(input int seed, input bit gaps, input string tag);
    int b_en, b_rise, b_done, b_nnr, b_ok, acc, late;
    bit seen;
    logic [CHAIN_LEN-1:0] exp_chain;
    b_en = en_cnt; b_rise = en_rise; b_done = done_cnt; b_nnr = nnr_cnt; b_ok = done_ok;
    exp_chain = expected_chain(seed);
    start_load();
    drive_bytes(seed, gaps, 0, acc);
    wait_done(late, seen);
    @(negedge clk);
    vectors++; if (acc !== NUM_BYTES) begin miscompares++; $display("FAIL %s bytes_accepted got %0d want %0d", tag, acc, NUM_BYTES); end
    vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL %s done_seen got %b want 1", tag, seen); end
    vectors++; if ((en_cnt - b_en) !== EXP_EN) begin miscompares++; $display("FAIL %s config_en_cycles got %0d want %0d", tag, en_cnt - b_en, EXP_EN); end
    if (gaps) begin
      vectors++; if ((en_rise - b_rise) < 2) begin miscompares++; $display("FAIL %s config_en_runs got %0d want >=2", tag, en_rise - b_rise); end
    end else begin
      vectors++; if ((en_rise - b_rise) !== 1) begin miscompares++; $display("FAIL %s config_en_runs got %0d want 1", tag, en_rise - b_rise); end
    end
    vectors++; if ((done_cnt - b_done) !== 1) begin miscompares++; $display("FAIL %s done_pulses got %0d want 1", tag, done_cnt - b_done); end
    vectors++; if ((nnr_cnt - b_nnr) !== 1) begin miscompares++; $display("FAIL %s nn_reset_pulses got %0d want 1", tag, nnr_cnt - b_nnr); end
    vectors++; if ((done_ok - b_ok) !== 1) begin miscompares++; $display("FAIL %s done_after_last_en got %0d want 1", tag, done_ok - b_ok); end
    vectors++; if (late !== 0) begin miscompares++; $display("FAIL %s ready_after_last_byte got %0d want 0", tag, late); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL %s busy_after_done got %b want 0", tag, busy); end
    vectors++; if (verify_err !== 1'b0) begin miscompares++; $display("FAIL %s verify_err got %b want 0", tag, verify_err); end
    vectors++; if (chain !== exp_chain) begin miscompares++; $display("FAIL %s chain got %h want %h", tag, chain, exp_chain); end
  endtask

  task automatic test_reset_mid_load();
    int acc, b_en;
    b_en = en_cnt;
    start_load();
    drive_bytes(11, 1'b0, 100, acc);
    #2 rst_n = 1'b0;
    stream.din_valid = 1'b0;
    #1;
    vectors++; if ((en_cnt - b_en) < 100) begin miscompares++; $display("FAIL midreset_bits_before_reset got %0d want >=100", en_cnt - b_en); end
    vectors++; if ({config_en, bs_out, stream.din_ready, nn_reset, busy, done, verify_err} !== 7'b0) begin
      miscompares++;
      $display("FAIL midreset_outputs got %b want 0000000",
               {config_en, bs_out, stream.din_ready, nn_reset, busy, done, verify_err});
    end
    @(negedge clk); rst_n = 1'b1;
    test_full_load(23, 1'b0, "after_reset");
  endtask

  task automatic test_abort();
    int acc, b_done, b_nnr;
    start_load();
    drive_bytes(37, 1'b0, 200, acc);
    abort = 1'b1;
    stream.din_valid = 1'b0;
    @(negedge clk); abort = 1'b0;
    vectors++; if ({busy, config_en, stream.din_ready} !== 3'b000) begin miscompares++; $display("FAIL abort_idle busy/en/ready got %b want 000", {busy, config_en, stream.din_ready}); end
    b_done = done_cnt; b_nnr = nnr_cnt;
    repeat (20) @(negedge clk);
    vectors++; if ((done_cnt - b_done) !== 0) begin miscompares++; $display("FAIL abort_no_done got %0d want 0", done_cnt - b_done); end
    vectors++; if ((nnr_cnt - b_nnr) !== 0) begin miscompares++; $display("FAIL abort_no_nn_reset got %0d want 0", nnr_cnt - b_nnr); end
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_beats_start busy got %b want 0", busy); end
    test_full_load(37, 1'b0, "after_abort");
  endtask

`ifdef RETOSPECT_CFG_READBACK_EN
  task automatic test_readback_fault();
    int acc, late;
    bit seen;
    stuck_en = 1'b1;
    start_load();
    drive_bytes(51, 1'b0, 0, acc);
    wait_done(late, seen);
    @(negedge clk);
    vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL fault_done_seen got %b want 1", seen); end
    vectors++; if (verify_err !== 1'b1) begin miscompares++; $display("FAIL fault_verify_err got %b want 1", verify_err); end
    start_load();
    vectors++; if ({busy, verify_err} !== 2'b10) begin miscompares++; $display("FAIL fault_cleared_on_start busy/err got %b want 10", {busy, verify_err}); end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    stuck_en = 1'b0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    start = 1'b0;
    abort = 1'b0;
    stream.din = 8'h00;
    stream.din_valid = 1'b0;
    test_reset();
    test_full_load(5, 1'b0, "no_gaps");
    test_full_load(5, 1'b1, "with_gaps");
    test_reset_mid_load();
    test_abort();
`ifdef RETOSPECT_CFG_READBACK_EN
    test_readback_fault();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/retospect_cfg_loader.md
# retospect_cfg_loader

Byte-parallel to bit-serial configuration loader for the neurochip configuration chain (clockbox followed by the cnb array). It accepts configuration bytes over a valid/ready stream, shifts exactly CHAIN_LEN bits into the chain's `bs_in` with `config_en` asserted, and then pulses the network reset. An optional build adds a readback pass that recirculates the chain non-destructively and checks a CRC.

## Interface
- `CHAIN_LEN`, 523: total chain bits. Clockbox contributes 6×8; each cnb contributes 19 (25 cnbs).
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load; ignored unless state is IDLE.
- `abort`  in  1  returns the block to IDLE from any state.
- `din`  in  8  configuration byte, LSB shifted first.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  byte accepted when `din_valid && din_ready`.
- `config_en`  out  1  drives the chain's `config_en`.
- `bs_out`  out  1  drives the chain's `bs_in`.
- `bs_in`  in  1  driven by the chain tail's `bs_out`.
- `nn_reset`  out  1  drives the chain's `reset_nn`; one-cycle pulse.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when the load completes.
- `verify_err`  out  1  sticky; cleared on `start`.

## Operation
- States: IDLE, LOAD, VERIFY (only with the macro), FINISH.
- IDLE → LOAD on `start`. Entering LOAD clears the bit counter, the byte-bit counter and `verify_err`, and presets the CRC to 0xFFFF.
- LOAD behaviour:
  - The shifter holds one byte. A shift occurs on each cycle the shifter holds at least one unsent bit.
  - A shift sets `config_en`=1 and drives `bs_out` with the current bit, then increments the bit counter.
  - When the shifter is empty, `config_en`=0 and the chain holds its contents (stall).
  - `din_ready` = LOAD && (shifter empty || last bit of the byte is shifting this cycle). This allows back-to-back bytes with no bubble.
- Final byte: the load ends when the bit counter reaches CHAIN_LEN. Unused high bits of the final byte are discarded; with the default, only bits [2:0] of byte 66 are used. `din_ready` stays 0 after the last byte is accepted.
- Leaving LOAD: goes to VERIFY (macro defined) or FINISH (macro undefined).
- FINISH: `nn_reset`=1 and `done`=1 for exactly one cycle, then IDLE.
- `abort` in any state: IDLE on the next edge, with `config_en`=0 and no `done`. The chain is left partially loaded, which is acceptable. `abort` and `start` in the same cycle: `abort` wins.
- Bit counter width is $clog2(CHAIN_LEN+1). It never wraps, because completion is detected on equality.

## Timing
- Reset values: `config_en`=0, `bs_out`=0, `din_ready`=0, `nn_reset`=0, `busy`=0, `done`=0, `verify_err`=0. State is IDLE and the CRC is 0xFFFF.
- In LOAD, `config_en` and `bs_out` are registered. A byte accepted at edge N has bit 0 on `bs_out` during cycle N+1, and the chain captures it at edge N+2.
- A minimum load, with `din_valid` held high, makes exactly CHAIN_LEN consecutive `config_en`=1 cycles.
- `done` and `nn_reset` assert in the cycle after the last `config_en`=1 cycle, or after the last VERIFY cycle when the macro is defined.

## Configuration
- `RETOSPECT_CFG_READBACK_EN` defined:
  - During LOAD, a bit-serial CRC-16-CCITT (poly 0x1021, init 0xFFFF) is computed over the shifted bits.
  - VERIFY then runs CHAIN_LEN cycles with `config_en`=1 and `bs_out` = `bs_in`. This mux is combinational on the registered state, so the loop length is exactly CHAIN_LEN and the chain is restored.
  - A second CRC is computed over `bs_in` during VERIFY. If the two CRCs differ at the end, `verify_err` is set.
  - `din_ready` is 0 throughout VERIFY.
- Macro undefined: VERIFY, the CRCs and the recirculation mux are absent. `verify_err` is tied to 0 and LOAD goes directly to FINISH.

## Structure
- A shared package, `retospect_cfg_pkg`, holds:
  - the state enum;
  - chain-length constants: CLOCKBOX_BITS=48, CNB_BITS=19, X_MAX/Y_MAX=5, and derived CHAIN_LEN;
  - CRC_POLY=16'h1021 and CRC_INIT=16'hFFFF.
- Sub-module `retospect_crc16_serial`: 1-bit input, enable and clear; instantiated twice.

## Test plan
- Reset mid-LOAD (after 100 bits): all outputs return to their reset values immediately; a subsequent `start` performs a clean full load.
- 66 bytes with `din_valid` held high, against a chain model → exactly 523 `config_en` cycles with no gaps, followed by one `done` and one `nn_reset`, with `busy` low afterward. Model contents equal the stream bits 0..522.
- Random `din_valid` gaps → `config_en` drops during gaps and the chain contents are identical to the no-gap case.
- `abort` at bit 200 → IDLE the next cycle, no `done`, and the bit counter restarts at 0 on the next `start`.
- Readback build, fault-free chain → 1046 total `config_en` cycles, `verify_err`=0, and the chain still holds the loaded pattern.
- Readback build with one model bit forced to 1 → `verify_err`=1 after `done`. The next `start` clears it.
